// File: rtl/esn_st_pkg.sv
// Shared widths, saturation constants and FIFO entry layout for the
// ESN Avalon-ST packer.
package esn_st_pkg;

   localparam int DEF_IN_W    = 16;
   localparam int DEF_EST_W   = 32;
   localparam int DEF_OUT_W   = 16;
   localparam int DEF_DROP    = 5;
   localparam int DEF_DEPTH   = 16;
   localparam int DEF_PKT_LEN = 64;

   // Largest / smallest signed value of a w-bit word, zero-extended.
   function automatic logic [63:0] sat_pos(input int w);
      return (64'd1 << (w - 1)) - 64'd1;
   endfunction

   function automatic logic [63:0] sat_neg(input int w);
      return 64'd1 << (w - 1);
   endfunction

   // FIFO entry is {sop, eop, data[dw-1:0]}.
   localparam int ENT_DATA = 0;

   function automatic int ent_eop(input int dw);
      return dw;
   endfunction

   function automatic int ent_sop(input int dw);
      return dw + 1;
   endfunction

endpackage

// File: rtl/esn_st_packer_if.sv
// Avalon-ST source stream between the packer and the host path.
// master drives valid/data/framing, slave drives ready.
interface esn_st_packer_if #(
   parameter int DW = 32
);

   logic          src_valid;
   logic          src_ready;
   logic [DW-1:0] src_data;
   logic          src_sop;
   logic          src_eop;

   modport master (
      output src_valid,
      output src_data,
      output src_sop,
      output src_eop,
      input  src_ready
   );

   modport slave (
      input  src_valid,
      input  src_data,
      input  src_sop,
      input  src_eop,
      output src_ready
   );

endinterface

// File: rtl/esn_st_fifo.sv
// Synchronous show-ahead FIFO with a registered head word; a push
// while full is taken only when a pop frees a slot in the same cycle.
module esn_st_fifo
   import esn_st_pkg::*;
#(
   parameter int W     = DEF_IN_W + DEF_OUT_W + 2,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] rd_nxt;
   logic [AW:0]   count;
   logic [W-1:0]  head_q;
   logic          push_ok;
   logic          pop_ok;

   // Qualify requests and find the slot that becomes the head.
   always_comb begin
      empty   = (count == '0);
      full    = (count == (AW+1)'(DEPTH));
      pop_ok  = pop && !empty;
      push_ok = push && (!full || pop_ok);
      rd_nxt  = pop_ok ? rd_ptr + 1'b1 : rd_ptr;
   end

   // Storage array; no reset needed, contents are gated by count.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers, occupancy and the registered head word.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         head_q <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         rd_ptr <= rd_nxt;
         count  <= count + {{AW{1'b0}}, push_ok}
                         - {{AW{1'b0}}, pop_ok};
         if (push_ok && (wr_ptr == rd_nxt)) begin
            head_q <= din;
         end else begin
            head_q <= mem[rd_nxt];
         end
      end
   end

   assign dout = head_q;

endmodule

// File: rtl/esn_st_packer.sv
// ESN estimate saturator, word packer and Avalon-ST packet framer.
// Define ESN_ST_ASCII_EN for 7-bit ASCII-safe byte packing.
module esn_st_packer
   import esn_st_pkg::*;
#(
   parameter int IN_W    = DEF_IN_W,
   parameter int EST_W   = DEF_EST_W,
   parameter int OUT_W   = DEF_OUT_W,
   parameter int DROP    = DEF_DROP,
   parameter int DEPTH   = DEF_DEPTH,
   parameter int PKT_LEN = DEF_PKT_LEN
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   input  logic [IN_W-1:0]  in_u,
   input  logic [EST_W-1:0] in_est,
   esn_st_packer_if.master  src,
   input  logic             clear_stats,
   output logic [15:0]      sat_count,
   output logic [15:0]      ovf_count
);

   localparam int DW    = IN_W + OUT_W;
   localparam int FW    = DW + 2;
   localparam int E_EOP = ent_eop(DW);
   localparam int E_SOP = ent_sop(DW);
   localparam int IW    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

   localparam logic [OUT_W-1:0] SAT_P = OUT_W'(sat_pos(OUT_W));
   localparam logic [OUT_W-1:0] SAT_N = OUT_W'(sat_neg(OUT_W));
   localparam logic [IW-1:0]    LAST  = IW'(PKT_LEN - 1);

   if (EST_W - 1 - DROP < OUT_W - 1) begin : g_bad_drop
      $error("esn_st_packer: DROP leaves fewer than OUT_W bits");
   end

`ifdef ESN_ST_ASCII_EN
   if (IN_W != 16 || OUT_W != 16) begin : g_bad_ascii
      $error("esn_st_packer: ASCII packing needs IN_W=OUT_W=16");
   end
`endif

   logic [DROP:0]   est_top;
   logic            in_range;
   logic            sat_hit;
   logic [OUT_W-1:0] y;
   logic [DW-1:0]   word;
   logic            s1_valid;
   logic [DW-1:0]   s1_word;
   logic [IW-1:0]   idx;
   logic            full;
   logic            empty;
   logic            pop;
   logic            push_ok;
   logic            drop_hit;
   logic [FW-1:0]   fifo_din;
   logic [FW-1:0]   fifo_dout;

   // Saturate the estimate into OUT_W bits and pack with the input.
   always_comb begin
      est_top  = in_est[EST_W-1 -: DROP+1];
      in_range = (est_top == '0) || (est_top == '1);
      sat_hit  = in_valid && !in_range;
      if (in_range) begin
         y = in_est[EST_W-1-DROP -: OUT_W];
      end else if (in_est[EST_W-1]) begin
         y = SAT_N;
      end else begin
         y = SAT_P;
      end
`ifdef ESN_ST_ASCII_EN
      word = {1'b0, in_u[15:9], 1'b0, in_u[8:2],
              1'b0, y[15:9],    1'b0, y[8:2]};
`else
      word = {in_u, y};
`endif
   end

   // Stage 1: register the packed sample.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s1_valid <= 1'b0;
         s1_word  <= '0;
      end else begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_word <= word;
         end
      end
   end

   // Stage 2 push decision; full is relieved by a same-cycle pop.
   always_comb begin
      pop      = !empty && src.src_ready;
      push_ok  = s1_valid && (!full || pop);
      drop_hit = s1_valid && full && !pop;
      fifo_din = {(idx == '0), (idx == LAST), s1_word};
   end

   // Packet index advances only on accepted words.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         idx <= '0;
      end else if (push_ok) begin
         idx <= (idx == LAST) ? '0 : idx + 1'b1;
      end
   end

   // Saturating statistics; clear wins over a same-cycle event.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sat_count <= '0;
         ovf_count <= '0;
      end else begin
         if (clear_stats) begin
            sat_count <= '0;
         end else if (sat_hit && sat_count != 16'hFFFF) begin
            sat_count <= sat_count + 16'd1;
         end
         if (clear_stats) begin
            ovf_count <= '0;
         end else if (drop_hit && ovf_count != 16'hFFFF) begin
            ovf_count <= ovf_count + 16'd1;
         end
      end
   end

   esn_st_fifo #(
      .W     (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push_ok),
      .din     (fifo_din),
      .pop     (pop),
      .dout    (fifo_dout),
      .full    (full),
      .empty   (empty)
   );

   assign src.src_valid = !empty;
   assign src.src_data  = fifo_dout[ENT_DATA +: DW];
   assign src.src_sop   = fifo_dout[E_SOP];
   assign src.src_eop   = fifo_dout[E_EOP];

endmodule
